// File: rtl/exe_if.sv
// Execute-stage bus: ID-register inputs toward the EXE stage, registered results toward MEM.
interface exe_if #(parameter int DW = 32, parameter int RW = 5);
    logic          in_valid;
    logic [3:0]    EXE_CMD;
    logic [DW-1:0] Val1;
    logic [DW-1:0] Val2;
    logic [DW-1:0] Reg2_in;
    logic [RW-1:0] Dest_in;
    logic          MEM_R_EN_in;
    logic          MEM_W_EN_in;
    logic          WB_EN_in;
    logic          stall;
    logic          out_valid;
    logic [DW-1:0] ALU_result;
    logic [DW-1:0] Reg2;
    logic [RW-1:0] Dest;
    logic          MEM_R_EN;
    logic          MEM_W_EN;
    logic          WB_EN;

    modport master (
        output in_valid, EXE_CMD, Val1, Val2, Reg2_in, Dest_in,
               MEM_R_EN_in, MEM_W_EN_in, WB_EN_in,
        input  stall, out_valid, ALU_result, Reg2, Dest, MEM_R_EN, MEM_W_EN, WB_EN
    );

    modport slave (
        input  in_valid, EXE_CMD, Val1, Val2, Reg2_in, Dest_in,
               MEM_R_EN_in, MEM_W_EN_in, WB_EN_in,
        output stall, out_valid, ALU_result, Reg2, Dest, MEM_R_EN, MEM_W_EN, WB_EN
    );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU plus iterative MUL/DIVU/REMU (DW steps), results registered.
// stall holds upstream from acceptance of a long op until its DONE cycle.
module exe_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    exe_if.slave bus
);
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic          stall;
    logic          is_long;
    logic          start;
    logic [CW-1:0] cnt;
    logic [3:0]    cmd_q;
    logic [DW:0]   acc;
    logic [DW-1:0] reg_a, reg_b;
    logic [DW:0]   r_sh, acc_nxt;
    logic [DW-1:0] a_nxt, b_nxt;
    logic          ge;
    logic [DW-1:0] alu_res, long_res;
    logic [4:0]    shamt;

    logic [DW-1:0] reg2_h;
    logic [RW-1:0] dest_h;
    logic          mem_r_h, mem_w_h, wb_h;

    logic          out_valid_q, mem_r_q, mem_w_q, wb_q;
    logic [DW-1:0] result_q, reg2_q;
    logic [RW-1:0] dest_q;

    assign is_long = (bus.EXE_CMD == 4'b1100) || (bus.EXE_CMD == 4'b1101) ||
                     (bus.EXE_CMD == 4'b1110);
    assign start   = (state == IDLE) && bus.in_valid && is_long && !flush;
    assign shamt   = bus.Val2[4:0];

    always_comb begin
        alu_res = '0;
        case (bus.EXE_CMD)
            4'b0000: alu_res = bus.Val1 + bus.Val2;
            4'b0010: alu_res = bus.Val1 - bus.Val2;
            4'b0100: alu_res = bus.Val1 & bus.Val2;
            4'b0101: alu_res = bus.Val1 | bus.Val2;
            4'b0110: alu_res = ~(bus.Val1 | bus.Val2);
            4'b0111: alu_res = bus.Val1 ^ bus.Val2;
            4'b1000: alu_res = bus.Val1 << shamt;
            4'b1001: alu_res = $signed(bus.Val1) >>> shamt;
            4'b1010: alu_res = bus.Val1 >> shamt;
            4'b1011: alu_res = {{(DW-1){1'b0}}, $signed(bus.Val1) < $signed(bus.Val2)};
            default: alu_res = '0;
        endcase
    end

    // MUL: shift-add on (acc, multiplier reg_a, multiplicand reg_b).
    // DIV: restoring divide; reg_a shifts dividend out and quotient in, acc is the remainder.
    // A zero divisor naturally yields all-ones quotient and remainder = dividend.
    always_comb begin
        r_sh = {acc[DW-1:0], reg_a[DW-1]};
        ge   = r_sh >= {1'b0, reg_b};
        if (cmd_q == 4'b1100) begin
            acc_nxt = acc + (reg_a[0] ? {1'b0, reg_b} : '0);
            a_nxt   = reg_a >> 1;
            b_nxt   = reg_b << 1;
        end else begin
            acc_nxt = ge ? (r_sh - {1'b0, reg_b}) : r_sh;
            a_nxt   = {reg_a[DW-2:0], ge};
            b_nxt   = reg_b;
        end
    end

    always_comb begin
        long_res = acc[DW-1:0];
        if (cmd_q == 4'b1101) long_res = reg_a;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        if (rst || flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (bus.in_valid && is_long) begin
                    stall     = 1'b1;
                    state_nxt = BUSY;
                end
                BUSY: begin
                    stall = 1'b1;
                    if (cnt == CW'(DW-1)) state_nxt = DONE;
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            cmd_q   <= '0;
            acc     <= '0;
            reg_a   <= '0;
            reg_b   <= '0;
            reg2_h  <= '0;
            dest_h  <= '0;
            mem_r_h <= 1'b0;
            mem_w_h <= 1'b0;
            wb_h    <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            cmd_q   <= bus.EXE_CMD;
            acc     <= '0;
            reg_a   <= bus.Val1;
            reg_b   <= bus.Val2;
            reg2_h  <= bus.Reg2_in;
            dest_h  <= bus.Dest_in;
            mem_r_h <= bus.MEM_R_EN_in;
            mem_w_h <= bus.MEM_W_EN_in;
            wb_h    <= bus.WB_EN_in;
        end else if (state == BUSY) begin
            cnt   <= cnt + 1'b1;
            acc   <= acc_nxt;
            reg_a <= a_nxt;
            reg_b <= b_nxt;
        end
    end

    // Result and pass-through keep their last values when nothing completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            reg2_q      <= '0;
            dest_q      <= '0;
            mem_r_q     <= 1'b0;
            mem_w_q     <= 1'b0;
            wb_q        <= 1'b0;
        end else if (!flush && state == IDLE && bus.in_valid && !is_long) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
            reg2_q      <= bus.Reg2_in;
            dest_q      <= bus.Dest_in;
            mem_r_q     <= bus.MEM_R_EN_in;
            mem_w_q     <= bus.MEM_W_EN_in;
            wb_q        <= bus.WB_EN_in;
        end else if (!flush && state == DONE) begin
            out_valid_q <= 1'b1;
            result_q    <= long_res;
            reg2_q      <= reg2_h;
            dest_q      <= dest_h;
            mem_r_q     <= mem_r_h;
            mem_w_q     <= mem_w_h;
            wb_q        <= wb_h;
        end else begin
            out_valid_q <= 1'b0;
            mem_r_q     <= 1'b0;
            mem_w_q     <= 1'b0;
            wb_q        <= 1'b0;
        end
    end

    assign bus.stall      = stall;
    assign bus.out_valid  = out_valid_q;
    assign bus.ALU_result = result_q;
    assign bus.Reg2       = reg2_q;
    assign bus.Dest       = dest_q;
    assign bus.MEM_R_EN   = mem_r_q;
    assign bus.MEM_W_EN   = mem_w_q;
    assign bus.WB_EN      = wb_q;
endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed vectors feed a scoreboard queue; a negedge monitor pops and compares.
module tb_exe_stage;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    exe_if #(.DW(32), .RW(5)) bus();
    exe_stage #(.DW(32), .RW(5)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] reg2;
        logic [4:0]  dest;
        logic        mr;
        logic        mw;
        logic        wb;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t mon_got;
    int total = 0;
    int bad   = 0;

    always @(negedge clk) begin
        mon_got = {bus.ALU_result, bus.Reg2, bus.Dest, bus.MEM_R_EN, bus.MEM_W_EN, bus.WB_EN};
        if (bus.out_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output got=%h (nothing expected)", mon_got);
            end else begin
                mon_e = sb.pop_front();
                if (mon_got !== mon_e) begin
                    bad++;
                    $display("FAIL result got res=%h reg2=%h dest=%0d mr=%b mw=%b wb=%b exp res=%h reg2=%h dest=%0d mr=%b mw=%b wb=%b",
                             mon_got.res, mon_got.reg2, mon_got.dest, mon_got.mr, mon_got.mw, mon_got.wb,
                             mon_e.res, mon_e.reg2, mon_e.dest, mon_e.mr, mon_e.mw, mon_e.wb);
                end
            end
        end else begin
            total++;
            if ({bus.MEM_R_EN, bus.MEM_W_EN, bus.WB_EN} !== 3'b000) begin
                bad++;
                $display("FAIL idle_enables got=%b exp=000", {bus.MEM_R_EN, bus.MEM_W_EN, bus.WB_EN});
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [4:0] dest, input logic wb, input logic mr, input logic mw,
                         input logic [31:0] r2);
        bus.in_valid    = 1'b1;
        bus.EXE_CMD     = cmd;
        bus.Val1        = v1;
        bus.Val2        = v2;
        bus.Dest_in     = dest;
        bus.WB_EN_in    = wb;
        bus.MEM_R_EN_in = mr;
        bus.MEM_W_EN_in = mw;
        bus.Reg2_in     = r2;
    endtask

    // Presents one instruction and holds it while stall is high; returns after the edge that releases it.
    task automatic issue(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [4:0] dest, input logic wb, input logic mr, input logic mw,
                         input logic [31:0] r2, input logic [31:0] exp_res, output int stalls);
        bit released;
        drive(cmd, v1, v2, dest, wb, mr, mw, r2);
        sb.push_back({exp_res, r2, dest, mr, mw, wb});
        stalls   = 0;
        released = 1'b0;
        for (int i = 0; i < 100 && !released; i++) begin
            @(negedge clk);
            if (!bus.stall) released = 1'b1;
            else stalls++;
            @(posedge clk); #1;
        end
        if (!released) begin
            total++;
            bad++;
            $display("FAIL stall_timeout got=%0d stalled cycles exp=release", stalls);
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[8] = '{
        '{4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000},
        '{4'b0101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0},
        '{4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F},
        '{4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0},
        '{4'b1000, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000},
        '{4'b1001, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000},
        '{4'b1010, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000},
        '{4'b0011, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000}
    };

    vec_t lvecs[4] = '{
        '{4'b1101, 32'd100, 32'd7, 32'd14},
        '{4'b1110, 32'd100, 32'd7, 32'd2},
        '{4'b1101, 32'd9,   32'd0, 32'hFFFF_FFFF},
        '{4'b1110, 32'd9,   32'd0, 32'd9}
    };

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        rst   = 1'b1;
        flush = 1'b0;
        drive(4'b0000, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_result", bus.ALU_result, 32'h0);
        chk("reset_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("reset_stall", {31'b0, bus.stall}, 32'h0);
        chk("reset_dest", {27'b0, bus.Dest}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        issue(4'b0000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 32'd12, st);
        bus.in_valid = 1'b0;
        chk("add_stall_cycles", st, 0);
        @(negedge clk);
        chk("add_out_valid", {31'b0, bus.out_valid}, 32'h1);
        idle(2);

        issue(4'b1011, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0, 32'd1, st);
        issue(4'b0010, 32'd3, 32'd5, 5'd5, 1'b0, 1'b0, 1'b1, 32'h0000_DEAD, 32'hFFFF_FFFE, st);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("sub_no_bubble", {31'b0, bus.out_valid}, 32'h1);
        idle(2);

        foreach (vecs[i])
            issue(vecs[i].cmd, vecs[i].v1, vecs[i].v2, 5'(i + 8), 1'b1, 1'b0, 1'b0, 32'(i), vecs[i].res, st);
        idle(2);

        issue(4'b1100, 32'h0000_FFFF, 32'h0001_0001, 5'd9, 1'b1, 1'b0, 1'b0, 32'h55, 32'hFFFF_FFFF, st);
        bus.in_valid = 1'b0;
        chk("mul_stall_cycles", st, 33);
        @(negedge clk);
        chk("mul_out_valid_T34", {31'b0, bus.out_valid}, 32'h1);
        @(negedge clk);
        chk("mul_no_duplicate", {31'b0, bus.out_valid}, 32'h0);
        idle(2);

        foreach (lvecs[i]) begin
            issue(lvecs[i].cmd, lvecs[i].v1, lvecs[i].v2, 5'(i + 20), 1'b1, 1'b1, 1'b0, 32'(i), lvecs[i].res, st);
            chk("div_stall_cycles", st, 33);
        end
        idle(2);

        drive(4'b1100, 32'd3, 32'd4, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_stall_low", {31'b0, bus.stall}, 32'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_no_out_valid", {31'b0, bus.out_valid}, 32'h0);
        idle(40);
        issue(4'b0000, 32'd1, 32'd2, 5'd6, 1'b1, 1'b0, 1'b0, 32'hBEEF, 32'd3, st);
        chk("post_flush_add_stall", st, 0);
        idle(2);

        drive(4'b1101, 32'd100, 32'd7, 5'd2, 1'b1, 1'b0, 1'b0, 32'h77);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_result", bus.ALU_result, 32'h0);
        chk("rst_reg2", bus.Reg2, 32'h0);
        chk("rst_dest", {27'b0, bus.Dest}, 32'h0);
        chk("rst_wb", {31'b0, bus.WB_EN}, 32'h0);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("rst_stall", {31'b0, bus.stall}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(4'b0000, 32'd2, 32'd2, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0, 32'd4, st);
        chk("post_rst_add_stall", st, 0);
        idle(40);

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
